// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter: FSM states, port-select
// encoding and default widths.
package unified_mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF       = 32;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  // Access sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } arb_state_e;

  // Result of one arbitration decision
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_IF   = 2'd1,
    SEL_D    = 2'd2
  } port_sel_e;

  // Width of a counter able to hold 0..limit (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_arb_pick.sv
// Combinational 2-way priority picker.
// Ports:
//   d_req_i      data port request
//   if_req_i     fetch port request
//   starve_hit_i fetch has waited the maximum number of data grants
//   mask_i       [0] masks fetch, [1] masks data (port that just completed)
//   pick_c_o     selected port (combinational)
module unified_mem_arbiter_arb_pick
  import unified_mem_arbiter_pkg::*;
(
  input  logic       d_req_i,
  input  logic       if_req_i,
  input  logic       starve_hit_i,
  input  logic [1:0] mask_i,
  output port_sel_e  pick_c_o
);

  logic d_eff;
  logic i_eff;

  // Data wins ties unless the fetch side has been starved long enough
  always_comb begin
    pick_c_o = SEL_NONE;
    d_eff    = d_req_i & ~mask_i[1];
    i_eff    = if_req_i & ~mask_i[0];
    if (d_eff && i_eff) begin
      pick_c_o = starve_hit_i ? SEL_IF : SEL_D;
    end else if (d_eff) begin
      pick_c_o = SEL_D;
    end else if (i_eff) begin
      pick_c_o = SEL_IF;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port req/ack memory between the fetch port and the data
// port. Each access is sequenced through IDLE -> GNT_x and completes on
// mem_ack_i; the ack cycle re-arbitrates so accesses can run back-to-back.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   if_req_i/if_addr_i              fetch request (held until if_valid_o)
//   if_rdata_o/if_valid_o           fetched word, one-cycle completion pulse
//   d_req_i/d_we_i/d_addr_i/d_wdata_i  data request (held until d_valid_o)
//   d_rdata_o/d_valid_o             load data, one-cycle completion pulse
//   stall_if_o/stall_mem_o          combinational per-port stalls
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  memory request (held until ack)
//   mem_rdata_i/mem_ack_i           memory response
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch port
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  // data port
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_valid_o,
  // stalls
  output logic              stall_if_o,
  output logic              stall_mem_o,
  // memory side
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int unsigned CNT_W = cnt_width(STARVE_LIMIT);

  arb_state_e        state_q,     state_d;
  logic [CNT_W-1:0]  starve_q,    starve_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_valid_q,  if_valid_d;
  logic              d_valid_q,   d_valid_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;

  logic       starve_hit;
  logic [1:0] grant_mask;
  port_sel_e  pick;

  // Fetch may jump the queue once it has watched STARVE_LIMIT data grants
  assign starve_hit = (STARVE_LIMIT != 0) && (starve_q == CNT_W'(STARVE_LIMIT));

  // The port finishing this cycle must not win the re-arbitration
  assign grant_mask = {state_q == ST_GNT_D, state_q == ST_GNT_I};

  unified_mem_arbiter_arb_pick u_pick (
    .d_req_i      (d_req_i),
    .if_req_i     (if_req_i),
    .starve_hit_i (starve_hit),
    .mask_i       (grant_mask),
    .pick_c_o     (pick)
  );

  // Next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    // Completion of the access in flight
    if (mem_ack_i) begin
      case (state_q)
        ST_GNT_I: begin
          if_valid_d = 1'b1;
          if_rdata_d = mem_rdata_i;
        end
        ST_GNT_D: begin
          d_valid_d = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata_i;
          end
        end
        default: ;
      endcase
    end

    // Arbitrate when idle or on the ack cycle of a grant
    if ((state_q == ST_IDLE) || mem_ack_i) begin
      case (pick)
        SEL_IF: begin
          state_d     = ST_GNT_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          starve_d    = '0;
        end
        SEL_D: begin
          state_d     = ST_GNT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          if (if_req_i && !starve_hit && (STARVE_LIMIT != 0)) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end
        default: begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_valid_o  = if_valid_q;
  assign d_valid_o   = d_valid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;

  assign stall_if_o  = if_req_i & ~if_valid_q;
  assign stall_mem_o = d_req_i & ~d_valid_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios followed by
// randomized requesters and memory, checked every cycle against a
// transaction-level reference model.
module tb_unified_mem_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          ack = 1'b0;
  logic [DW-1:0] rdata = '0;

  logic [DW-1:0] if_rdata_o, d_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic          if_valid_o, d_valid_o, stall_if_o, stall_mem_o, mem_req_o, mem_we_o;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_rdata_o  (if_rdata_o),
    .if_valid_o  (if_valid_o),
    .d_req_i     (d_req),
    .d_we_i      (d_we),
    .d_addr_i    (d_addr),
    .d_wdata_i   (d_wdata),
    .d_rdata_o   (d_rdata_o),
    .d_valid_o   (d_valid_o),
    .stall_if_o  (stall_if_o),
    .stall_mem_o (stall_mem_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (rdata),
    .mem_ack_i   (ack)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: who owns the memory (0 none, 1 fetch, 2 data), how many
  // data grants the fetch side has watched, and the expected register outputs.
  int            owner;
  int            starve;
  bit            e_req, e_we, e_if_valid, e_d_valid;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_if_rdata, e_d_rdata;

  task automatic model_reset();
    owner = 0; starve = 0;
    e_req = 0; e_we = 0; e_if_valid = 0; e_d_valid = 0;
    e_addr = '0; e_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
  endtask

  // Advance the model by one clock edge using the inputs now applied
  task automatic model_step();
    bit can_i, can_d;
    int pick;
    e_if_valid = 0;
    e_d_valid  = 0;
    if (owner == 1 && ack) begin
      e_if_valid = 1;
      e_if_rdata = rdata;
    end
    if (owner == 2 && ack) begin
      e_d_valid = 1;
      if (!e_we) e_d_rdata = rdata;
    end
    if (owner == 0 || ack) begin
      can_i = if_req && (owner != 1);
      can_d = d_req && (owner != 2);
      pick = 0;
      if (can_i && can_d) pick = (LIM != 0 && starve == LIM) ? 1 : 2;
      else if (can_d) pick = 2;
      else if (can_i) pick = 1;
      owner = pick;
      if (pick == 1) begin
        e_req = 1; e_we = 0; e_addr = if_addr; starve = 0;
      end else if (pick == 2) begin
        e_req = 1; e_we = d_we; e_addr = d_addr; e_wdata = d_wdata;
        if (if_req && starve < LIM) starve++;
      end else begin
        e_req = 0;
      end
    end
  endtask

  task automatic compare_regs();
    chk("mem_req", mem_req_o, e_req);
    chk("if_valid", if_valid_o, e_if_valid);
    chk("d_valid", d_valid_o, e_d_valid);
    chk("if_rdata", if_rdata_o, e_if_rdata);
    chk("d_rdata", d_rdata_o, e_d_rdata);
    if (e_req) begin
      chk("mem_addr", mem_addr_o, e_addr);
      chk("mem_we", mem_we_o, e_we);
      if (e_we) chk("mem_wdata", mem_wdata_o, e_wdata);
    end
  endtask

  // One clock: check stalls on the applied inputs, predict, clock, compare
  task automatic cycle();
    #1;
    chk("stall_if", stall_if_o, if_req & ~e_if_valid);
    chk("stall_mem", stall_mem_o, d_req & ~e_d_valid);
    model_step();
    @(posedge clk);
    #1;
    compare_regs();
    ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, mem_req_o, 0);
    chk({tag, "_we"}, mem_we_o, 0);
    chk({tag, "_addr"}, mem_addr_o, 0);
    chk({tag, "_wdata"}, mem_wdata_o, 0);
    chk({tag, "_ifv"}, if_valid_o, 0);
    chk({tag, "_dv"}, d_valid_o, 0);
    chk({tag, "_ifrd"}, if_rdata_o, 0);
    chk({tag, "_drd"}, d_rdata_o, 0);
    chk({tag, "_stalls"}, {stall_if_o, stall_mem_o}, 0);
  endtask

  initial begin
    int lat;
    logic [DW-1:0] saved;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: fetch only, ack three cycles after the grant
    if_req = 1; if_addr = 32'h100;
    cycle();
    chk("t1_addr", mem_addr_o, 32'h100);
    chk("t1_we", mem_we_o, 0);
    cycle();
    cycle();
    ack = 1; rdata = 32'h0050_0093;
    cycle();
    chk("t1_valid", if_valid_o, 1);
    chk("t1_rdata", if_rdata_o, 32'h0050_0093);
    if_req = 0;
    cycle();
    chk("t1_valid_once", if_valid_o, 0);

    // 2: simultaneous requests, data first, fetch follows with no gap
    if_req = 1; if_addr = 32'h200;
    d_req = 1; d_we = 0; d_addr = 32'h80;
    cycle();
    chk("t2_data_first", mem_addr_o, 32'h80);
    ack = 1; rdata = 32'h1111_2222;
    cycle();
    chk("t2_dvalid", d_valid_o, 1);
    chk("t2_drdata", d_rdata_o, 32'h1111_2222);
    chk("t2_no_gap", mem_req_o, 1);
    chk("t2_fetch_addr", mem_addr_o, 32'h200);
    d_req = 0; ack = 1; rdata = 32'h3333_4444;
    cycle();
    chk("t2_ifvalid", if_valid_o, 1);
    chk("t2_ifrdata", if_rdata_o, 32'h3333_4444);
    if_req = 0;
    cycle();

    // 3: write leaves load data untouched
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    cycle();
    chk("t3_we", mem_we_o, 1);
    chk("t3_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    ack = 1; rdata = 32'hBAD0_BAD0;
    cycle();
    chk("t3_dvalid", d_valid_o, 1);
    chk("t3_drdata_kept", d_rdata_o, 32'h1111_2222);
    d_req = 0; d_we = 0;
    cycle();

    // 4: four data grants watched by a fetch, then the fetch wins a tie
    for (int i = 0; i < 4; i++) begin
      if_req = 1; if_addr = 32'h300;
      d_req = 1; d_addr = 32'h500 + 32'(i * 4);
      cycle();
      chk("t4_data_grant", mem_addr_o, 32'h500 + 32'(i * 4));
      if_req = 0; ack = 1; rdata = $urandom;
      cycle();
      d_req = 0;
      cycle();
    end
    if_req = 1; d_req = 1; d_addr = 32'h600;
    cycle();
    chk("t4_fetch_wins", mem_addr_o, 32'h300);
    chk("t4_fetch_we", mem_we_o, 0);
    d_req = 0; ack = 1; rdata = $urandom;
    cycle();
    if_req = 0;
    cycle();
    if_req = 1; d_req = 1; d_addr = 32'h604;
    cycle();
    chk("t4_data_again", mem_addr_o, 32'h604);
    if_req = 0; ack = 1; rdata = $urandom;
    cycle();
    d_req = 0;
    cycle();

    // 6: fetch dropped after grant still completes, nothing reissued
    if_req = 1; if_addr = 32'h700;
    cycle();
    chk("t6_req", mem_req_o, 1);
    if_req = 0;
    cycle();
    ack = 1; rdata = 32'h0000_0777;
    cycle();
    chk("t6_valid", if_valid_o, 1);
    cycle();
    chk("t6_no_reissue", mem_req_o, 0);
    cycle();

    // 5: reset in the middle of a data grant
    d_req = 1; d_we = 0; d_addr = 32'h900;
    cycle();
    chk("t5_in_grant", mem_req_o, 1);
    #2;
    d_req = 0; rst_n = 1'b0;
    #1;
    check_all_zero("t5_async");
    model_reset();
    ack = 1; rdata = $urandom;
    @(posedge clk);
    #1;
    chk("t5_no_valid", d_valid_o, 0);
    ack = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    if_req = 1; if_addr = 32'hA00;
    cycle();
    chk("t5_fetch_addr", mem_addr_o, 32'hA00);
    ack = 1; rdata = 32'hCAFE_F00D;
    cycle();
    chk("t5_fetch_data", if_rdata_o, 32'hCAFE_F00D);
    if_req = 0;
    cycle();

    // Randomized traffic with variable memory latency and spurious idle acks
    lat = 0;
    saved = '0;
    for (int n = 0; n < 3000; n++) begin
      if (e_if_valid) if_req = 0;
      else if (!if_req) begin
        if ($urandom % 3 == 0) begin if_req = 1; if_addr = $urandom; end
      end else if ($urandom % 16 == 0) if_req = 0;

      if (e_d_valid) d_req = 0;
      else if (!d_req) begin
        if ($urandom % 3 == 0) begin
          d_req = 1; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
        end
      end else if ($urandom % 16 == 0) d_req = 0;

      rdata = $urandom;
      saved = rdata;
      if (e_req) begin
        if (lat == 0) begin
          ack = 1;
          lat = int'($urandom % 4);
        end else begin
          lat--;
        end
      end else begin
        ack = ($urandom % 8 == 0);
      end
      cycle();
    end
    if (saved == '0) $display("note: last random rdata was zero");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
